// File: rtl/cache_ctrl_mesi_plru_pkg.sv
// Shared types for the MESI/PLRU cache controller: line states, bus ops, FSM states.
package cache_mesi_pkg;
  typedef enum logic [1:0] {MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11} mesi_t;
  typedef enum logic [1:0] {BUS_NONE = 2'b00, BUS_RD = 2'b01, BUS_RDX = 2'b10, BUS_INV = 2'b11} bus_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_COMMIT} fsm_t;
endpackage

// File: rtl/cache_ctrl_mesi_plru_if.sv
// Processor request, snoop bus and snoop-response signals of the cache controller.
interface cache_ctrl_mesi_plru_if #(
  parameter int ASSOC    = 4,
  parameter int NUM_SETS = 256
);
  localparam int WAY_W = $clog2(ASSOC);
  localparam int IDX_W = $clog2(NUM_SETS);

  logic             req_valid, req_ready, req_wr, req_hit;
  logic [IDX_W-1:0] req_index;
  logic [WAY_W-1:0] req_hit_way;
  logic [1:0]       req_cur_state;
  logic             bus_req, bus_gnt, bus_shared;
  logic [1:0]       bus_op;
  logic             done;
  logic [WAY_W-1:0] done_way;
  logic [1:0]       done_state;
  logic             snp_valid, snp_hit, snp_flush, snp_upd;
  logic [1:0]       snp_op, snp_cur_state, snp_new_state;
  logic [IDX_W-1:0] snp_index;
  logic [WAY_W-1:0] snp_way;

  modport master (
    output req_valid, req_wr, req_index, req_hit, req_hit_way, req_cur_state,
           bus_gnt, bus_shared, snp_valid, snp_op, snp_index, snp_way, snp_hit, snp_cur_state,
    input  req_ready, bus_req, bus_op, done, done_way, done_state,
           snp_new_state, snp_flush, snp_upd
  );
  modport slave (
    input  req_valid, req_wr, req_index, req_hit, req_hit_way, req_cur_state,
           bus_gnt, bus_shared, snp_valid, snp_op, snp_index, snp_way, snp_hit, snp_cur_state,
    output req_ready, bus_req, bus_op, done, done_way, done_state,
           snp_new_state, snp_flush, snp_upd
  );
endinterface

// File: rtl/cache_ctrl_mesi_plru_plru_tree.sv
// Tree pseudo-LRU: victim walk and path update. Node n has children 2n+1 / 2n+2;
// a node bit of 0 points to the lower-numbered half.
module plru_tree #(
  parameter  int ASSOC = 4,
  localparam int WAY_W = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0] bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [ASSOC-2:0] bits_nxt
);
  always_comb begin : victim_walk
    int node;
    node   = 0;
    victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = bits[node];
      node = 2*node + 1 + int'(bits[node]);
    end
  end

  // Every node on the path to the accessed way is turned to face the other half.
  always_comb begin : update_walk
    int node;
    node     = 0;
    bits_nxt = bits;
    for (int l = 0; l < WAY_W; l++) begin
      bits_nxt[node] = ~access_way[WAY_W-1-l];
      node = 2*node + 1 + int'(access_way[WAY_W-1-l]);
    end
  end
endmodule

// File: rtl/cache_ctrl_mesi_plru.sv
// Per-core MESI transaction FSM with per-set tree PLRU and a registered snoop path.
// Perf counters are built only when CACHE_CTRL_PERF_CNT_EN is defined.
module cache_ctrl_mesi_plru
  import cache_mesi_pkg::*;
#(
  parameter  int ASSOC    = 4,
  parameter  int NUM_SETS = 256,
  parameter  int CNT_W    = 32,
  localparam int WAY_W    = $clog2(ASSOC),
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_ctrl_mesi_plru_if.slave  bus_if,
  output logic [CNT_W-1:0]       cnt_hit,
  output logic [CNT_W-1:0]       cnt_miss,
  output logic [CNT_W-1:0]       cnt_snp_inv
);
  fsm_t             state, state_nxt;
  bus_op_t          op_q, op_nxt;
  logic             wr_q, hit_q, shared_q;
  logic [IDX_W-1:0] idx_q;
  logic [WAY_W-1:0] way_q, victim;
  mesi_t            cur_q, req_cur, done_st, snp_cur, snp_ns;
  logic [ASSOC-2:0] plru_mem [NUM_SETS];
  logic [ASSOC-2:0] tree_bits, tree_nxt;
  logic             eff_hit, no_bus, upg_loss, snp_fl, snp_up;

  assign req_cur = mesi_t'(bus_if.req_cur_state);
  assign eff_hit = bus_if.req_hit && (req_cur != MESI_I);
  assign no_bus  = eff_hit && (req_cur != MESI_S || !bus_if.req_wr);
  assign done_st = wr_q ? MESI_M : hit_q ? cur_q : shared_q ? MESI_S : MESI_E;

  // One tree instance: IDLE looks up the victim, COMMIT computes the updated bits.
  assign tree_bits = (state == ST_COMMIT) ? plru_mem[idx_q] : plru_mem[bus_if.req_index];
  plru_tree #(.ASSOC(ASSOC)) u_plru (
    .bits(tree_bits), .access_way(way_q), .victim(victim), .bits_nxt(tree_nxt)
  );

  // Another cache won the race for our line: the pending upgrade must refetch.
  assign upg_loss = (op_q == BUS_INV) && bus_if.snp_valid && bus_if.snp_hit &&
                    (bus_if.snp_op == BUS_RDX || bus_if.snp_op == BUS_INV) &&
                    (bus_if.snp_index == idx_q) && (bus_if.snp_way == way_q);

  always_comb begin
    state_nxt         = state;
    op_nxt            = op_q;
    bus_if.req_ready  = 1'b0;
    bus_if.bus_req    = 1'b0;
    bus_if.bus_op     = BUS_NONE;
    bus_if.done       = 1'b0;
    bus_if.done_way   = '0;
    bus_if.done_state = MESI_I;
    case (state)
      ST_IDLE: begin
        bus_if.req_ready = 1'b1;
        if (bus_if.req_valid) begin
          state_nxt = no_bus ? ST_COMMIT : ST_BUS;
          op_nxt    = !eff_hit ? (bus_if.req_wr ? BUS_RDX : BUS_RD) : BUS_INV;
        end
      end
      ST_BUS: begin
        bus_if.bus_req = 1'b1;
        bus_if.bus_op  = op_q;
        if (bus_if.bus_gnt) state_nxt = ST_COMMIT;
        else if (upg_loss)  op_nxt    = BUS_RDX;
      end
      ST_COMMIT: begin
        bus_if.done       = 1'b1;
        bus_if.done_way   = way_q;
        bus_if.done_state = done_st;
        state_nxt         = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= BUS_NONE;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      shared_q <= 1'b0;
      idx_q    <= '0;
      way_q    <= '0;
      cur_q    <= MESI_I;
      for (int s = 0; s < NUM_SETS; s++) plru_mem[s] <= '0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      if (state == ST_IDLE && bus_if.req_valid) begin
        wr_q  <= bus_if.req_wr;
        hit_q <= eff_hit;
        idx_q <= bus_if.req_index;
        way_q <= eff_hit ? bus_if.req_hit_way : victim;
        cur_q <= req_cur;
      end
      if (state == ST_BUS && bus_if.bus_gnt) shared_q <= bus_if.bus_shared;
      if (state == ST_COMMIT) plru_mem[idx_q] <= tree_nxt;
    end
  end

  assign snp_cur = mesi_t'(bus_if.snp_cur_state);
  always_comb begin
    snp_ns = MESI_I;
    snp_fl = 1'b0;
    snp_up = 1'b0;
    if (bus_if.snp_valid && bus_if.snp_hit) begin
      case (snp_cur)
        MESI_M: if (bus_if.snp_op == BUS_RD || bus_if.snp_op == BUS_RDX) begin
          snp_up = 1'b1;
          snp_fl = 1'b1;
          snp_ns = (bus_if.snp_op == BUS_RD) ? MESI_S : MESI_I;
        end
        MESI_E: if (bus_if.snp_op == BUS_RD || bus_if.snp_op == BUS_RDX) begin
          snp_up = 1'b1;
          snp_ns = (bus_if.snp_op == BUS_RD) ? MESI_S : MESI_I;
        end
        MESI_S: if (bus_if.snp_op == BUS_RDX || bus_if.snp_op == BUS_INV) snp_up = 1'b1;
        default: snp_up = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_if.snp_new_state <= MESI_I;
      bus_if.snp_flush     <= 1'b0;
      bus_if.snp_upd       <= 1'b0;
    end else begin
      bus_if.snp_new_state <= snp_ns;
      bus_if.snp_flush     <= snp_fl;
      bus_if.snp_upd       <= snp_up;
    end
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hit     <= '0;
      cnt_miss    <= '0;
      cnt_snp_inv <= '0;
    end else begin
      if (state == ST_COMMIT && hit_q && cnt_hit != '1)   cnt_hit  <= cnt_hit + CNT_W'(1);
      if (state == ST_COMMIT && !hit_q && cnt_miss != '1) cnt_miss <= cnt_miss + CNT_W'(1);
      if (snp_up && snp_ns == MESI_I && cnt_snp_inv != '1) cnt_snp_inv <= cnt_snp_inv + CNT_W'(1);
    end
  end
`else
  assign cnt_hit     = '0;
  assign cnt_miss    = '0;
  assign cnt_snp_inv = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl_mesi_plru.sv
// Randomized bench for cache_ctrl_mesi_plru against a transaction-level model
// (PLRU modelled from per-way access timestamps, not tree bits).
module tb_cache_ctrl_mesi_plru;
  import cache_mesi_pkg::*;
  localparam int ASSOC = 4, NUM_SETS = 256, CNT_W = 32;
  localparam int WAY_W = $clog2(ASSOC), IDX_W = $clog2(NUM_SETS);

  logic clk, rst;
  logic [CNT_W-1:0] cnt_hit, cnt_miss, cnt_snp_inv;
  cache_ctrl_mesi_plru_if #(.ASSOC(ASSOC), .NUM_SETS(NUM_SETS)) bif ();

  cache_ctrl_mesi_plru #(.ASSOC(ASSOC), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus_if(bif),
    .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_snp_inv(cnt_snp_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0, rand_snp = 0;
  logic             e_ready, e_breq, e_done, e_sflush, e_supd;
  logic [1:0]       e_bop, e_dstate, e_sns;
  logic [WAY_W-1:0] e_dway;
  int unsigned      m_hit, m_miss, m_inv, tick;
  int unsigned      ts [NUM_SETS][ASSOC];
  logic [1:0]       cap_first, cap_last, cap_dstate;
  logic [WAY_W-1:0] cap_dway;
  logic             prev_breq = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("req_ready", 64'(bif.req_ready), 64'(e_ready));
    check("bus_req", 64'(bif.bus_req), 64'(e_breq));
    check("bus_op", 64'(bif.bus_op), 64'(e_bop));
    check("done", 64'(bif.done), 64'(e_done));
    check("done_way", 64'(bif.done_way), 64'(e_dway));
    check("done_state", 64'(bif.done_state), 64'(e_dstate));
    check("snp_upd", 64'(bif.snp_upd), 64'(e_supd));
    check("snp_new_state", 64'(bif.snp_new_state), 64'(e_sns));
    check("snp_flush", 64'(bif.snp_flush), 64'(e_sflush));
`ifdef CACHE_CTRL_PERF_CNT_EN
    check("cnt_hit", 64'(cnt_hit), 64'(m_hit));
    check("cnt_miss", 64'(cnt_miss), 64'(m_miss));
    check("cnt_snp_inv", 64'(cnt_snp_inv), 64'(m_inv));
`else
    check("cnt_hit", 64'(cnt_hit), 64'(0));
    check("cnt_miss", 64'(cnt_miss), 64'(0));
    check("cnt_snp_inv", 64'(cnt_snp_inv), 64'(0));
`endif
    if (bif.bus_req && !prev_breq) cap_first <= bif.bus_op;
    if (bif.bus_req) cap_last <= bif.bus_op;
    prev_breq <= bif.bus_req;
    if (bif.done) begin
      cap_dway   <= bif.done_way;
      cap_dstate <= bif.done_state;
    end
  end

  // Most recent access time among n ways starting at lo (0 = never touched).
  function automatic int unsigned max_ts(input int s, input int lo, input int n);
    int unsigned m = 0;
    for (int w = lo; w < lo + n; w++) if (ts[s][w] > m) m = ts[s][w];
    return m;
  endfunction

  // Each tree level steers away from the half that holds the latest access under it.
  function automatic int model_victim(input int s);
    int lo = 0, size = ASSOC, half;
    while (size > 1) begin
      half = size / 2;
      if (max_ts(s, lo, half) > max_ts(s, lo + half, half)) lo += half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void snp_model(input logic v, input logic h, input logic [1:0] op,
                                    input logic [1:0] cur, output logic [1:0] ns,
                                    output logic fl, output logic up);
    ns = 2'b00; fl = 1'b0; up = 1'b0;
    if (v && h) begin
      if (cur == 2'b11 && op == 2'b01)      begin ns = 2'b01; fl = 1'b1; up = 1'b1; end
      else if (cur == 2'b11 && op == 2'b10) begin ns = 2'b00; fl = 1'b1; up = 1'b1; end
      else if (cur == 2'b10 && op == 2'b01) begin ns = 2'b01; up = 1'b1; end
      else if (cur == 2'b10 && op == 2'b10) begin ns = 2'b00; up = 1'b1; end
      else if (cur == 2'b01 && op[1])       begin ns = 2'b00; up = 1'b1; end
    end
  endfunction

  task automatic exp_idle();
    e_ready = 1'b1; e_breq = 1'b0; e_bop = 2'b00;
    e_done = 1'b0; e_dway = '0; e_dstate = 2'b00;
  endtask

  task automatic set_snp(input logic v, input logic [1:0] op, input int idx, input int way,
                         input logic h, input logic [1:0] cur);
    bif.snp_valid = v; bif.snp_op = op; bif.snp_index = IDX_W'(idx);
    bif.snp_way = WAY_W'(way); bif.snp_hit = h; bif.snp_cur_state = cur;
  endtask

  task automatic rand_snoop();
    if (rand_snp)
      set_snp(1'($urandom), 2'($urandom), $urandom_range(0, 7), $urandom_range(0, ASSOC-1),
              1'($urandom), 2'($urandom));
    else set_snp(1'b0, 2'b00, 0, 0, 1'b0, 2'b00);
  endtask

  // Advance one edge; snoop expectations follow from the inputs seen at that edge.
  task automatic cyc();
    logic [1:0] ns; logic fl, up;
    snp_model(bif.snp_valid, bif.snp_hit, bif.snp_op, bif.snp_cur_state, ns, fl, up);
    @(posedge clk); #1;
    if (rst) begin
      e_sns = 2'b00; e_sflush = 1'b0; e_supd = 1'b0;
      m_hit = 0; m_miss = 0; m_inv = 0;
    end else begin
      e_sns = ns; e_sflush = fl; e_supd = up;
      if (up && ns == 2'b00) m_inv++;
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < NUM_SETS; s++) for (int w = 0; w < ASSOC; w++) ts[s][w] = 0;
    tick = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bif.req_valid = 1'b0; bif.bus_gnt = 1'b0; bif.bus_shared = 1'b0;
    set_snp(1'b0, 2'b00, 0, 0, 1'b0, 2'b00);
    cyc(); exp_idle(); clear_model(); chk_en = 1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic idle_cyc();
    rand_snoop(); cyc();
  endtask

  task automatic do_req(input logic wr, input int idx, input logic hit, input int hway,
                        input logic [1:0] cur, input logic shared, input int gdly, input int upg);
    int way; bit eh, nobus; logic [1:0] op, nop, nst;
    eh    = hit && cur != 2'b00;
    nobus = eh && (cur != 2'b01 || !wr);
    way   = eh ? hway : model_victim(idx);
    op    = !eh ? (wr ? 2'b10 : 2'b01) : 2'b11;
    bif.req_valid = 1'b1; bif.req_wr = wr; bif.req_index = IDX_W'(idx); bif.req_hit = hit;
    bif.req_hit_way = WAY_W'(hway); bif.req_cur_state = cur;
    rand_snoop(); cyc();
    bif.req_valid = 1'b0; bif.req_index = IDX_W'($urandom); bif.req_hit = 1'($urandom);
    e_ready = 1'b0;
    if (!nobus) begin
      e_breq = 1'b1; e_bop = op;
      for (int c = 0; c <= gdly; c++) begin
        bit g;
        g = (c == gdly);
        bif.bus_gnt = g; bif.bus_shared = g ? shared : 1'($urandom);
        if (c == upg) set_snp(1'b1, 2'b10, idx, way, 1'b1, 2'($urandom));
        else rand_snoop();
        nop = e_bop;
        if (!g && e_bop == 2'b11 && bif.snp_valid && bif.snp_hit && bif.snp_op[1] &&
            bif.snp_index == IDX_W'(idx) && bif.snp_way == WAY_W'(way)) nop = 2'b10;
        cyc();
        e_bop = nop;
      end
      bif.bus_gnt = 1'b0; e_breq = 1'b0; e_bop = 2'b00;
    end
    nst = wr ? 2'b11 : eh ? cur : shared ? 2'b01 : 2'b10;
    e_done = 1'b1; e_dway = WAY_W'(way); e_dstate = nst;
    rand_snoop(); cyc();
    ts[idx][way] = ++tick;
    if (eh) m_hit++; else m_miss++;
    exp_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int vseq [4];
    vseq = '{0, 2, 1, 3};
    do_reset();
    check("rst_req_ready", 64'(bif.req_ready), 64'(1));
    check("rst_bus_op", 64'(bif.bus_op), 64'(0));
    check("rst_done_state", 64'(bif.done_state), 64'(0));

    // Read miss, unshared, granted on the fourth bus cycle.
    do_req(1'b0, 5, 1'b0, 0, 2'b00, 1'b0, 3, -1);
    check("rdmiss_op", 64'(cap_first), 64'(2'b01));
    check("rdmiss_state", 64'(cap_dstate), 64'(2'b10));
    check("rdmiss_way", 64'(cap_dway), 64'(0));
    check("model_next_victim", 64'(model_victim(5)), 64'(2));

    // Write hit on S loses the upgrade race to a snooped BusRdX.
    do_req(1'b1, 7, 1'b1, 1, 2'b01, 1'b0, 4, 1);
    check("upg_first_op", 64'(cap_first), 64'(2'b11));
    check("upg_last_op", 64'(cap_last), 64'(2'b10));
    check("upg_state", 64'(cap_dstate), 64'(2'b11));
    check("upg_way", 64'(cap_dway), 64'(1));

    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, 0, 1'b0, 0, 2'b00, 1'b1, 1, -1);
      check("victim_seq", 64'(cap_dway), 64'(vseq[k]));
    end
    check("rdmiss_shared_state", 64'(cap_dstate), 64'(2'b01));

    set_snp(1'b1, 2'b01, 3, 2, 1'b1, 2'b11); cyc();
    check("snp_m_rd_state", 64'(bif.snp_new_state), 64'(2'b01));
    check("snp_m_rd_flush", 64'(bif.snp_flush), 64'(1));
    set_snp(1'b1, 2'b10, 3, 2, 1'b0, 2'b11); cyc();
    check("snp_miss_upd", 64'(bif.snp_upd), 64'(0));
    set_snp(1'b0, 2'b00, 0, 0, 1'b0, 2'b00); cyc();

    // Reset while waiting for grant drops the request.
    bif.req_valid = 1'b1; bif.req_wr = 1'b0; bif.req_index = IDX_W'(9); bif.req_hit = 1'b0;
    bif.req_hit_way = '0; bif.req_cur_state = 2'b00;
    cyc();
    bif.req_valid = 1'b0; e_ready = 1'b0; e_breq = 1'b1; e_bop = 2'b01;
    cyc();
    rst = 1'b1; cyc(); exp_idle(); clear_model();
    check("rst_bus_bus_req", 64'(bif.bus_req), 64'(0));
    check("rst_bus_ready", 64'(bif.req_ready), 64'(1));
    rst = 1'b0;
    repeat (3) idle_cyc();

    // Two hits and one miss for the counters.
    do_req(1'b0, 9, 1'b1, 2, 2'b10, 1'b0, 0, -1);
    do_req(1'b1, 9, 1'b1, 3, 2'b11, 1'b0, 0, -1);
    do_req(1'b0, 10, 1'b0, 0, 2'b00, 1'b0, 0, -1);
`ifdef CACHE_CTRL_PERF_CNT_EN
    check("cnt_hit_lit", 64'(cnt_hit), 64'(2));
    check("cnt_miss_lit", 64'(cnt_miss), 64'(1));
`else
    check("cnt_hit_lit", 64'(cnt_hit), 64'(0));
    check("cnt_miss_lit", 64'(cnt_miss), 64'(0));
`endif

    rand_snp = 1;
    repeat (300) begin
      int gd;
      gd = $urandom_range(0, 4);
      do_req(1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, ASSOC-1),
             2'($urandom), 1'($urandom), gd,
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, gd) : -1);
      repeat ($urandom_range(0, 1)) idle_cyc();
    end
    rand_snp = 0;
    idle_cyc(); idle_cyc();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
